// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer
// Drains a FRAME_BYTES-deep transmit buffer once it reports full. Each byte goes out
// on tx as 8N1, LSB first. After each stop bit, buf_rd pulses once. After the last
// byte the block waits for buf_full to drop before it re-arms.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   buf_full    buffer holds a complete frame
//   buf_data    buffer data at its current read pointer (combinational)
//   buf_rd      one-cycle read strobe, advances the buffer read pointer
//   tx          serial output, idles high
//   busy        high whenever the sequencer is not idle
//   frame_done  one-cycle pulse in the cycle after the last byte's strobe
module uart_tx_sequencer #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FRAME_BYTES  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       buf_full,
    input  logic [7:0] buf_data,
    output logic       buf_rd,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned ByteW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [ByteW-1:0] ByteLast = ByteW'(FRAME_BYTES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StData,
        StStop,
        StAck,
        StWaitClr
    } state_e;

    state_e           state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [ByteW-1:0] byte_q, byte_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             buf_rd_q, buf_rd_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             baud_end;

    assign baud_end = (baud_q == BaudLast);

    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        byte_d       = byte_q;
        shift_d      = shift_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (buf_full) state_d = StLoad;
            end
            StLoad: begin
                // The read pointer moved on the previous edge, so buf_data is settled here.
                shift_d = buf_data;
                baud_d  = '0;
                state_d = StStart;
            end
            StStart: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;  // wraps 7 -> 0 on the way out
                    if (bit_q == 3'd7) state_d = StStop;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = StAck;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StAck: begin
                if (byte_q == ByteLast) begin
                    byte_d       = '0;
                    frame_done_d = 1'b1;
                    state_d      = StWaitClr;
                end else begin
                    byte_d  = byte_q + 1'b1;
                    state_d = StLoad;
                end
            end
            StWaitClr: begin
                // Hold off until full clears so a stale frame is never re-sent.
                if (!buf_full) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state, so they line up with state_q.
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        buf_rd_d = (state_d == StAck);
        busy_d   = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            baud_q       <= '0;
            bit_q        <= '0;
            byte_q       <= '0;
            shift_q      <= '0;
            tx_q         <= 1'b1;
            buf_rd_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            byte_q       <= byte_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            buf_rd_q     <= buf_rd_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx         = tx_q;
    assign buf_rd     = buf_rd_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: a 4-byte buffer model feeds two instances
// (CLKS_PER_BIT=4 and 2). Expected line activity comes from a per-cycle frame model.
module tb_uart_tx_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, buf_full, sel, ptr_rst;
    logic [7:0] buf_data;
    logic [7:0] buf_mem [4];
    logic [1:0] ptr;
    logic       rd1, tx1, busy1, fd1, rd2, tx2, busy2, fd2;
    logic       rd_s, tx_s, busy_s, fd_s;

    int n_checks = 0;
    int n_err    = 0;

    uart_tx_sequencer #(.CLKS_PER_BIT(4), .FRAME_BYTES(4)) dut (
        .clk(clk), .rst_n(rst_n), .buf_full(buf_full), .buf_data(buf_data),
        .buf_rd(rd1), .tx(tx1), .busy(busy1), .frame_done(fd1)
    );

    uart_tx_sequencer #(.CLKS_PER_BIT(2), .FRAME_BYTES(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .buf_full(buf_full), .buf_data(buf_data),
        .buf_rd(rd2), .tx(tx2), .busy(busy2), .frame_done(fd2)
    );

    assign rd_s     = sel ? rd2 : rd1;
    assign tx_s     = sel ? tx2 : tx1;
    assign busy_s   = sel ? busy2 : busy1;
    assign fd_s     = sel ? fd2 : fd1;
    assign buf_data = buf_mem[ptr];

    // Buffer read pointer advances on each strobe from the selected instance.
    always @(posedge clk) begin
        if (ptr_rst) ptr <= 2'd0;
        else if (rd_s) ptr <= ptr + 2'd1;
    end

    typedef struct packed {
        logic tx;
        logic rd;
        logic fd;
        logic load;
    } cyc_t;
    cyc_t exp_q[$];

    typedef struct {
        logic [31:0] bytes;
        int          hold;
        int          drop_at;
        int          chg_at;
        int          exp_cycles;
        int          exp_rd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle-by-cycle picture of one frame: LOAD, start, 8 data bits, stop, ACK per byte,
    // then one cycle carrying frame_done.
    function automatic void build_model(input logic [31:0] bytes, input int cpb);
        logic [7:0] b;
        logic       lvl;
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            b = bytes[8*k +: 8];
            exp_q.push_back('{tx: 1'b1, rd: 1'b0, fd: 1'b0, load: 1'b1});
            for (int s = 0; s < 10; s++) begin
                if (s == 0) lvl = 1'b0;
                else if (s == 9) lvl = 1'b1;
                else lvl = b[s-1];
                for (int c = 0; c < cpb; c++)
                    exp_q.push_back('{tx: lvl, rd: 1'b0, fd: 1'b0, load: 1'b0});
            end
            exp_q.push_back('{tx: 1'b1, rd: 1'b1, fd: 1'b0, load: 1'b0});
        end
        exp_q.push_back('{tx: 1'b1, rd: 1'b0, fd: 1'b1, load: 1'b0});
    endfunction

    task automatic load_buffer(input logic [31:0] bytes);
        for (int i = 0; i < 4; i++) buf_mem[i] = bytes[8*i +: 8];
        ptr_rst = 1'b1;
        @(posedge clk);
        #1;
        ptr_rst = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [31:0] bytes, input int cpb,
                             input int hold, input int drop_at, input int chg_at,
                             output int cyc_to_fd, output int n_rd,
                             output logic [9:0] byte1_bits);
        int base;
        load_buffer(bytes);
        build_model(bytes, cpb);
        base       = 2 + 10 * cpb + 1;
        cyc_to_fd  = -1;
        n_rd       = 0;
        byte1_bits = '0;
        buf_full   = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s cyc%0d {tx,rd,fd,busy}", tag, k),
                  {28'd0, tx_s, rd_s, fd_s, busy_s},
                  {28'd0, exp_q[k].tx, exp_q[k].rd, exp_q[k].fd, 1'b1});
            if (rd_s) n_rd++;
            if (fd_s && cyc_to_fd < 0) cyc_to_fd = k + 1;
            if (k >= base && (k - base) % cpb == 0 && (k - base) / cpb < 10)
                byte1_bits[(k - base) / cpb] = tx_s;
            if (k == drop_at) buf_full = 1'b0;
            // Only disturb the byte already latched; a LOAD cycle would pick it up.
            if (k == chg_at && !exp_q[k].load) buf_mem[ptr] = ~buf_mem[ptr];
        end
        if (buf_full) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                check($sformatf("%s wait_clr%0d {tx,rd,fd,busy}", tag, h),
                      {28'd0, tx_s, rd_s, fd_s, busy_s}, 32'b1001);
                if (rd_s) n_rd++;
            end
            buf_full = 1'b0;
        end
        @(posedge clk);
        #1;
        check($sformatf("%s back to idle {tx,busy}", tag), {30'd0, tx_s, busy_s}, 32'b10);
    endtask

    vec_t       vecs [4];
    int         cyc, nrd;
    logic [9:0] bits;
    logic [31:0] rb;

    initial begin
        rst_n    = 1'b0;
        buf_full = 1'b0;
        sel      = 1'b0;
        ptr_rst  = 1'b1;
        for (int i = 0; i < 4; i++) buf_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset {tx,rd,fd,busy}", {28'd0, tx1, rd1, fd1, busy1}, 32'b1000);
        check("reset dut2 {tx,rd,fd,busy}", {28'd0, tx2, rd2, fd2, busy2}, 32'b1000);
        rst_n   = 1'b1;
        ptr_rst = 1'b0;

        // Idle with nothing buffered: line stays high, no strobes.
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("idle%0d {tx,rd,fd,busy}", i),
                  {28'd0, tx1, rd1, fd1, busy1}, 32'b1000);
        end

        vecs[0] = '{bytes: 32'hFF00A355, hold: 20, drop_at: -1, chg_at: -1,
                    exp_cycles: 169, exp_rd: 4};
        vecs[1] = '{bytes: 32'hFF00A355, hold: 0, drop_at: -1, chg_at: -1,
                    exp_cycles: 169, exp_rd: 4};
        vecs[2] = '{bytes: 32'h12345678, hold: 3, drop_at: -1, chg_at: 52,
                    exp_cycles: 169, exp_rd: 4};
        vecs[3] = '{bytes: 32'hC3817E01, hold: 0, drop_at: 60, chg_at: -1,
                    exp_cycles: 169, exp_rd: 4};

        for (int v = 0; v < 4; v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].bytes, 4, vecs[v].hold,
                      vecs[v].drop_at, vecs[v].chg_at, cyc, nrd, bits);
            check($sformatf("vec%0d cycles to frame_done", v), cyc, vecs[v].exp_cycles);
            check($sformatf("vec%0d strobe count", v), nrd, vecs[v].exp_rd);
            if (v == 0) check("vec0 byte 0xA3 line bits", {22'd0, bits}, 32'b1101000110);
        end

        // Randomized frames: random data, hold time, mid-frame full drop and data churn.
        for (int r = 0; r < 6; r++) begin
            rb = $urandom;
            run_frame($sformatf("rnd%0d", r), rb, 4, $urandom_range(0, 5),
                      ($urandom_range(0, 1) == 1) ? $urandom_range(0, 150) : -1,
                      $urandom_range(0, 160), cyc, nrd, bits);
            check($sformatf("rnd%0d cycles to frame_done", r), cyc, 169);
            check($sformatf("rnd%0d strobe count", r), nrd, 4);
        end

        // Reset in the middle of data bit 3 of byte 2.
        load_buffer(32'hA5A5A5A5);
        buf_full = 1'b1;
        for (int k = 0; k <= 102; k++) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset {tx,rd,fd,busy}", {28'd0, tx1, rd1, fd1, busy1}, 32'b1000);
        check("strobes before abort", {30'd0, ptr}, 32'd2);
        buf_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("held in reset {tx,busy}", {30'd0, tx1, busy1}, 32'b10);
        check("no strobe for aborted byte", {30'd0, ptr}, 32'd2);
        rst_n = 1'b1;
        run_frame("post_reset", 32'h0F1E2D3C, 4, 2, -1, -1, cyc, nrd, bits);
        check("post_reset cycles to frame_done", cyc, 169);
        check("post_reset strobe count", nrd, 4);

        // Two-clock bit period instance.
        sel = 1'b1;
        run_frame("cpb2", 32'h80808080, 2, 4, -1, -1, cyc, nrd, bits);
        check("cpb2 cycles to frame_done", cyc, 89);
        check("cpb2 strobe count", nrd, 4);
        check("cpb2 byte 0x80 line bits", {22'd0, bits}, 32'b1100000000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_sequencer.md
Name: uart_tx_sequencer

Overview:
Downstream consumer of the 4-byte UART transmit buffer. It waits until the buffer reports full, then serialises the four bytes in 8N1 format on the tx line, LSB first. After each byte's stop bit it pulses buf_rd once so the buffer advances its read pointer. When all four bytes are sent it waits for the buffer to clear full before it re-arms.

Parameters:
CLKS_PER_BIT, 434, clk cycles per serial bit (434 = 50 MHz / 115200); legal range is 2 or more.
FRAME_BYTES, 4, bytes drained per buffer fill; must match buffer depth.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst_n  input  1  asynchronous active-low reset.
buf_full  input  1  buffer full flag; high means a frame is ready.
buf_data  input  8  buffer read data for the current read pointer (combinational from the buffer).
buf_rd  output  1  one-cycle read strobe; advances the buffer read pointer on its rising edge.
tx  output  1  serial line; idles high.
busy  output  1  high in every state except IDLE.
frame_done  output  1  one-cycle pulse after the last byte's strobe.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: tx=1, buf_rd=0, busy=0, frame_done=0, state=IDLE; baud counter, bit counter, byte counter and shift register all 0.
- Reset mid-operation: tx returns to 1 immediately without waiting for a clock edge, and any partial byte is abandoned.
- All outputs are registered.
- States: IDLE, LOAD, START, DATA, STOP, ACK, WAIT_CLR.
- IDLE: tx=1. If buf_full is sampled high, go to LOAD.
- LOAD (1 cycle): shift_reg <= buf_data, baud counter <= 0, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit counter = 0.
- DATA: tx=shift_reg[0] for CLKS_PER_BIT cycles per bit, then shift right and increment the bit counter.
  - After bit 7 completes, go to STOP.
  - The bit counter is 3 bits and wraps 7->0 on exit.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to ACK.
- ACK (1 cycle): buf_rd=1 and the byte counter increments.
  - If the byte counter was FRAME_BYTES-1: counter <= 0, frame_done=1 in the following cycle, go to WAIT_CLR.
  - Otherwise go to LOAD. buf_data is sampled one cycle after the strobe, so the buffer's pointer has settled.
- WAIT_CLR: tx=1. Stay until buf_full is sampled low, then go to IDLE. This prevents re-sending a stale frame while full is still high.
- Baud counter: runs 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. Width is $clog2(CLKS_PER_BIT).
- Byte timing: 1 (LOAD) + 10*CLKS_PER_BIT + 1 (ACK) cycles per byte.
  - The first START edge appears 2 cycles after buf_full is first high in IDLE.
- buf_full dropping in the middle of a frame is ignored; the current frame always completes all FRAME_BYTES bytes.
- buf_data is sampled only in LOAD; changes at any other time have no effect.
- buf_rd is never high in two consecutive cycles, and never outside ACK.

Test Plan (CLKS_PER_BIT=4):
1. rst_n low, then high, with buf_full=0 for 100 cycles -> tx=1, busy=0, buf_rd never pulses.
2. Buffer loaded with 0x55,0xA3,0x00,0xFF, then buf_full=1 -> four 8N1 frames, LSB first.
   - Each frame: 40 bit-cycles plus LOAD and ACK, 42 cycles per byte.
   - 0xA3 appears as 0,1,1,0,0,0,1,0,1,1 (start, d0..d7, stop).
   - Exactly 4 buf_rd pulses, 42 cycles apart; frame_done once, 1 cycle after the 4th pulse.
3. Test model holds buf_full high after the 4th buf_rd -> block stays in WAIT_CLR with tx=1 and no 5th pulse.
   - buf_full drops -> IDLE. A new fill -> a second frame starting from byte 0.
4. rst_n asserted during DATA bit 3 of byte 2 -> tx=1, busy=0 asynchronously.
   - No buf_rd for the aborted byte; byte counter restarts at 0.
5. buf_data changed in the middle of byte 1 -> the transmitted bits match the value latched in LOAD.
6. CLKS_PER_BIT=2 build -> bit period is 2 cycles; a 0x80 frame shows d7=1 only, then the stop bit.
